// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared constants for the ALU sequencer: opcode values,
//             sequencer state encoding and instruction field positions.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

    // Instruction word layout: [15:12] opcode, [11:8] rd, [7:4] rs1, [3:0] rs2
    localparam int INSTR_W = 16;
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    // Opcodes; 4'hD..4'hF are reserved
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_INC = 4'h3;
    localparam logic [3:0] OP_DEC = 4'h4;
    localparam logic [3:0] OP_MUL = 4'h5;
    localparam logic [3:0] OP_SHR = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_AND = 4'h8;
    localparam logic [3:0] OP_OR  = 4'h9;
    localparam logic [3:0] OP_XOR = 4'hA;
    localparam logic [3:0] OP_NOT = 4'hB;
    localparam logic [3:0] OP_MOV = 4'hC;

    // Sequencer states
    localparam int         ST_W    = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_WB   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_seq_regfile.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_regfile
//  Purpose  : Register file for the ALU sequencer. Two combinational source
//             read ports, one combinational debug read port and one write
//             port muxed between sequencer writeback (priority) and an
//             external load. Synchronous active-low clear of all entries.
//  Ports    : clk, rst_n            clock / sync active-low clear
//             ra1/rd1, ra2/rd2      source read ports
//             dbg_addr/dbg_data     debug read port
//             wb_we/wb_addr/wb_data writeback write request
//             ext_we/ext_addr/ext_data external load request
//  Config   : ALU_SEQ_R0_ZERO_EN - register 0 hard-wired to zero
//  Revision : 1.0  initial release
// ============================================================================
module alu_seq_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    input  logic              wb_we,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data
);

    localparam int NREGS = 1 << REG_AW;

    logic [DATA_W-1:0] r_regs [NREGS];

    logic              w_we;
    logic [REG_AW-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    // Writeback wins; the sequencer already masks ext_we outside IDLE.
    always_comb begin
        w_we    = wb_we | ext_we;
        w_waddr = wb_we ? wb_addr : ext_addr;
        w_wdata = wb_we ? wb_data : ext_data;
`ifdef ALU_SEQ_R0_ZERO_EN
        if (w_waddr == '0) begin
            w_we = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[w_waddr] <= w_wdata;
        end
    end

`ifdef ALU_SEQ_R0_ZERO_EN
    assign rd1      = (ra1 == '0)      ? '0 : r_regs[ra1];
    assign rd2      = (ra2 == '0)      ? '0 : r_regs[ra2];
    assign dbg_data = (dbg_addr == '0) ? '0 : r_regs[dbg_addr];
`else
    assign rd1      = r_regs[ra1];
    assign rd2      = r_regs[ra2];
    assign dbg_data = r_regs[dbg_addr];
`endif

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Control stage ahead of the 16-bit logic unit. Accepts one
//             instruction per valid/ready handshake, presents the source
//             registers on bus1/bus2, fires one one-hot op strobe, then
//             pushes and writes the returned bus3 result to rd.
//             States: IDLE -> EXEC -> (WB ->) IDLE.
//  Ports    : clk, rst_n                 clock / sync active-low reset
//             instr_valid/instr_ready/instr  instruction handshake
//             bus1, bus2 (out), bus3 (in)    logic unit data buses
//             pass..bnegate                  one-hot op strobes
//             ext_we/ext_addr/ext_data       external register load
//             dbg_addr/dbg_data              debug register read
//             done, illegal                  one-cycle status pulses
//  Config   : ALU_SEQ_R0_ZERO_EN - register 0 reads as zero, writes dropped
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic [DATA_W-1:0] bus1,
    output logic [DATA_W-1:0] bus2,
    input  logic [DATA_W-1:0] bus3,
    output logic              pass,
    output logic              push,
    output logic              add,
    output logic              sub,
    output logic              inc,
    output logic              dec,
    output logic              mul,
    output logic              shr,
    output logic              shl,
    output logic              band,
    output logic              bor,
    output logic              bxor,
    output logic              bnegate,
    input  logic              ext_we,
    input  logic [REG_AW-1:0] ext_addr,
    input  logic [DATA_W-1:0] ext_data,
    input  logic [REG_AW-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic              done,
    output logic              illegal
);

    logic [ST_W-1:0]    r_state;
    logic [ST_W-1:0]    w_state_nxt;
    logic [INSTR_W-1:0] r_instr;
    logic               r_done;
    logic               r_illegal;
    logic               w_done_nxt;
    logic               w_illegal_nxt;
    logic               w_bus_en;
    logic               w_wb_we;
    logic               w_ext_we;

    logic [3:0]         w_op;
    logic [REG_AW-1:0]  w_rd;
    logic [REG_AW-1:0]  w_rs1;
    logic [REG_AW-1:0]  w_rs2;
    logic [DATA_W-1:0]  w_rd1;
    logic [DATA_W-1:0]  w_rd2;

    assign w_op  = r_instr[OP_MSB:OP_LSB];
    assign w_rd  = REG_AW'(r_instr[RD_MSB:RD_LSB]);
    assign w_rs1 = REG_AW'(r_instr[RS1_MSB:RS1_LSB]);
    assign w_rs2 = REG_AW'(r_instr[RS2_MSB:RS2_LSB]);

    // External loads only land in IDLE on an edge that is not accepting
    // an instruction, so they can never race a writeback.
    assign w_ext_we = ext_we && (r_state == ST_IDLE) && !instr_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_instr   <= '0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_done    <= w_done_nxt;
            r_illegal <= w_illegal_nxt;
            if (r_state == ST_IDLE && instr_valid) begin
                r_instr <= instr;
            end
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_done_nxt    = 1'b0;
        w_illegal_nxt = 1'b0;
        w_bus_en      = 1'b0;
        w_wb_we       = 1'b0;
        instr_ready   = 1'b0;
        pass          = 1'b0;
        push          = 1'b0;
        add           = 1'b0;
        sub           = 1'b0;
        inc           = 1'b0;
        dec           = 1'b0;
        mul           = 1'b0;
        shr           = 1'b0;
        shl           = 1'b0;
        band          = 1'b0;
        bor           = 1'b0;
        bxor          = 1'b0;
        bnegate       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                w_bus_en    = 1'b1;
                w_state_nxt = ST_IDLE;
                case (w_op)
                    OP_ADD: begin add     = 1'b1; w_state_nxt = ST_WB; end
                    OP_SUB: begin sub     = 1'b1; w_state_nxt = ST_WB; end
                    OP_INC: begin inc     = 1'b1; w_state_nxt = ST_WB; end
                    OP_DEC: begin dec     = 1'b1; w_state_nxt = ST_WB; end
                    OP_MUL: begin mul     = 1'b1; w_state_nxt = ST_WB; end
                    OP_SHR: begin shr     = 1'b1; w_state_nxt = ST_WB; end
                    OP_SHL: begin shl     = 1'b1; w_state_nxt = ST_WB; end
                    OP_AND: begin band    = 1'b1; w_state_nxt = ST_WB; end
                    OP_OR:  begin bor     = 1'b1; w_state_nxt = ST_WB; end
                    OP_XOR: begin bxor    = 1'b1; w_state_nxt = ST_WB; end
                    OP_NOT: begin bnegate = 1'b1; w_state_nxt = ST_WB; end
                    OP_MOV: begin
                        // pass is combinational through the logic unit,
                        // so the result is taken at the end of EXEC.
                        pass       = 1'b1;
                        w_wb_we    = 1'b1;
                        w_done_nxt = 1'b1;
                    end
                    OP_NOP: begin
                        w_done_nxt = 1'b1;
                    end
                    default: begin
                        w_illegal_nxt = 1'b1;
                    end
                endcase
            end
            ST_WB: begin
                push        = 1'b1;
                w_wb_we     = 1'b1;
                w_done_nxt  = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus1    = w_bus_en ? w_rd1 : '0;
    assign bus2    = w_bus_en ? w_rd2 : '0;
    assign done    = r_done;
    assign illegal = r_illegal;

    alu_seq_regfile #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .ra1      (w_rs1),
        .rd1      (w_rd1),
        .ra2      (w_rs2),
        .rd2      (w_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .wb_we    (w_wb_we),
        .wb_addr  (w_rd),
        .wb_data  (bus3),
        .ext_we   (w_ext_we),
        .ext_addr (ext_addr),
        .ext_data (ext_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Directed self-checking bench for alu_sequencer. The bench
//             plays the logic unit by driving bus3 with hand-computed
//             results for each instruction.
//  Config   : ALU_SEQ_R0_ZERO_EN changes the expected R0 readback
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [15:0]       instr;
    logic [DATA_W-1:0] bus1;
    logic [DATA_W-1:0] bus2;
    logic [DATA_W-1:0] bus3;
    logic pass, push, add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate;
    logic              ext_we;
    logic [REG_AW-1:0] ext_addr;
    logic [DATA_W-1:0] ext_data;
    logic [REG_AW-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              done;
    logic              illegal;

    int n_checks = 0;
    int n_errors = 0;

    // {pass,push,add,sub,inc,dec,mul,shr,shl,band,bor,bxor,bnegate}
    logic [12:0] w_strb;
    assign w_strb = {pass, push, add, sub, inc, dec, mul, shr, shl, band, bor, bxor, bnegate};

    localparam logic [12:0] STB_NONE = 13'h0000;
    localparam logic [12:0] STB_PASS = 13'h1000;
    localparam logic [12:0] STB_PUSH = 13'h0800;
    localparam logic [12:0] STB_ADD  = 13'h0400;
    localparam logic [12:0] STB_SUB  = 13'h0200;
    localparam logic [12:0] STB_MUL  = 13'h0040;

    alu_sequencer #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .bus1        (bus1),
        .bus2        (bus2),
        .bus3        (bus3),
        .pass        (pass),
        .push        (push),
        .add         (add),
        .sub         (sub),
        .inc         (inc),
        .dec         (dec),
        .mul         (mul),
        .shr         (shr),
        .shl         (shl),
        .band        (band),
        .bor         (bor),
        .bxor        (bxor),
        .bnegate     (bnegate),
        .ext_we      (ext_we),
        .ext_addr    (ext_addr),
        .ext_data    (ext_data),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data),
        .done        (done),
        .illegal     (illegal)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        assert ($onehot0(w_strb))
            else $error("more than one strobe high: %b", w_strb);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_load(input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] d);
        ext_we   = 1'b1;
        ext_addr = a;
        ext_data = d;
        tick();
        ext_we   = 1'b0;
    endtask

    task automatic read_reg(input string tag, input logic [REG_AW-1:0] a, input logic [DATA_W-1:0] exp);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Presents one instruction for the accept edge, then drops valid.
    task automatic issue(input logic [15:0] ins, input logic [DATA_W-1:0] res);
        instr       = ins;
        bus3        = res;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = '0;
        bus3        = '0;
        ext_we      = 1'b0;
        ext_addr    = '0;
        ext_data    = '0;
        dbg_addr    = '0;
        tick();
        tick();

        // Reset state
        check("rst_ready",   instr_ready, 1);
        check("rst_strobes", w_strb,      STB_NONE);
        check("rst_bus1",    bus1,        0);
        check("rst_bus2",    bus2,        0);
        check("rst_done",    done,        0);
        check("rst_illegal", illegal,     0);
        rst_n = 1'b1;

        // ADD R3 = R1 + R2 = 5 + 3
        ext_load(4'd1, 16'h0005);
        ext_load(4'd2, 16'h0003);
        read_reg("ld_r1", 4'd1, 16'h0005);
        read_reg("ld_r2", 4'd2, 16'h0003);
        issue(16'h1312, 16'h0008);
        check("add_exec_ready", instr_ready, 0);
        check("add_exec_bus1",  bus1,        16'h0005);
        check("add_exec_bus2",  bus2,        16'h0003);
        check("add_exec_stb",   w_strb,      STB_ADD);
        ext_we = 1'b1; ext_addr = 4'd2; ext_data = 16'hFFFF;   // must be ignored
        tick();
        ext_we = 1'b0;
        check("add_wb_stb",  w_strb, STB_PUSH);
        check("add_wb_bus1", bus1,   0);
        check("add_wb_done", done,   0);
        tick();
        check("add_done",   done,        1);
        check("add_ready",  instr_ready, 1);
        read_reg("add_r3", 4'd3, 16'h0008);
        read_reg("add_r2_noext", 4'd2, 16'h0003);
        tick();
        check("add_done_clr", done, 0);

        // MUL R4 = 0x0002 * 0x8001 -> low 16 bits 0x0002
        ext_load(4'd1, 16'h0002);
        ext_load(4'd2, 16'h8001);
        issue(16'h5412, 16'h0002);
        check("mul_exec_stb",  w_strb, STB_MUL);
        check("mul_exec_bus2", bus2,   16'h8001);
        tick();
        check("mul_wb_stb", w_strb, STB_PUSH);
        tick();
        check("mul_done", done, 1);
        read_reg("mul_r4", 4'd4, 16'h0002);

        // MOV R5 = R1, with an ext load on the accept edge that must be ignored
        ext_load(4'd1, 16'h1234);
        ext_we = 1'b1; ext_addr = 4'd6; ext_data = 16'hABCD;
        issue(16'hC510, 16'h1234);
        ext_we = 1'b0;
        check("mov_exec_stb",  w_strb, STB_PASS);
        check("mov_exec_bus1", bus1,   16'h1234);
        read_reg("mov_r5_before", 4'd5, 16'h0000);
        tick();
        check("mov_stb_after", w_strb, STB_NONE);
        check("mov_done",      done,   1);
        read_reg("mov_r5",       4'd5, 16'h1234);
        read_reg("mov_r6_noext", 4'd6, 16'h0000);

        // Reserved opcode 0xE
        issue(16'hE123, 16'h5555);
        check("ill_exec_stb", w_strb,  STB_NONE);
        check("ill_exec_ill", illegal, 0);
        tick();
        check("ill_pulse",    illegal,     1);
        check("ill_nodone",   done,        0);
        check("ill_ready",    instr_ready, 1);
        check("ill_stb",      w_strb,      STB_NONE);
        read_reg("ill_r1", 4'd1, 16'h1234);
        tick();
        check("ill_clr", illegal, 0);

        // NOP
        issue(16'h0000, 16'h0000);
        check("nop_exec_stb", w_strb, STB_NONE);
        tick();
        check("nop_ready", instr_ready, 1);

        // SUB R7 with reset during WB
        issue(16'h2712, 16'h1111);
        check("sub_exec_stb", w_strb, STB_SUB);
        tick();
        check("sub_wb_stb", w_strb, STB_PUSH);
        rst_n = 1'b0;
        tick();
        check("rstwb_stb",   w_strb,      STB_NONE);
        check("rstwb_done",  done,        0);
        check("rstwb_bus1",  bus1,        0);
        check("rstwb_ready", instr_ready, 1);
        read_reg("rstwb_r7", 4'd7, 16'h0000);
        rst_n = 1'b1;
        tick();
        check("rstwb_done2", done, 0);

        // ADD into R0
        ext_load(4'd1, 16'h00F0);
        ext_load(4'd2, 16'h000F);
        issue(16'h1012, 16'h00FF);
        tick();
        tick();
        check("r0_done", done, 1);
`ifdef ALU_SEQ_R0_ZERO_EN
        read_reg("r0_read", 4'd0, 16'h0000);
`else
        read_reg("r0_read", 4'd0, 16'h00FF);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
